// File: rtl/sync_ram_sp.sv
// Single-port synchronous RAM with independent write and read enables.
// Latency: read data registered, valid 1 cycle after the rd_en sampling edge.
// Backpressure: none; every enabled access completes on the sampling edge.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset; clears array and rdata to RESET_VALUE
//   addr       word address shared by read and write
//   wr_en      write enable, mem[addr] <= wdata
//   rd_en      read enable, rdata <= mem[addr] (read-before-write on collision)
//   wdata      write data
//   rdata      registered read data, holds when rd_en is low
//   parity_err (only with SYNC_RAM_PARITY_EN) registered parity mismatch of last read
//
// Optional feature macro: SYNC_RAM_PARITY_EN adds one even-parity bit per word
// and the parity_err output.
module sync_ram_sp #(
    parameter int                    ADDR_WIDTH  = 2,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] wdata,
`ifdef SYNC_RAM_PARITY_EN
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  parity_err
`else
    output logic [DATA_WIDTH-1:0] rdata
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Reading mem_q before the write lands gives read-before-write on a
    // same-address collision without any bypass logic.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = mem_q[addr];
        end
    end

    // Storage is plain flops so the whole array can be cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VALUE;
            end
            rdata_q <= RESET_VALUE;
        end else begin
            rdata_q <= rdata_d;
            if (wr_en) begin
                mem_q[addr] <= wdata;
            end
        end
    end

    assign rdata = rdata_q;

`ifdef SYNC_RAM_PARITY_EN
    logic par_q [DEPTH];
    logic parity_err_q;
    logic parity_err_d;

    // Stored bit is the XOR of the data, so data plus parity has even weight;
    // any single-bit upset in either makes the two disagree.
    always_comb begin
        parity_err_d = parity_err_q;
        if (rd_en) begin
            parity_err_d = (par_q[addr] != (^mem_q[addr]));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                par_q[i] <= ^RESET_VALUE;
            end
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
            if (wr_en) begin
                par_q[addr] <= ^wdata;
            end
        end
    end

    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_sync_ram_sp.sv
module tb_sync_ram_sp;

    logic       clk;
    logic       reset;
    logic [1:0] addr;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wdata;
    logic [7:0] rdata;
`ifdef SYNC_RAM_PARITY_EN
    logic       parity_err;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: an array of words plus the last value read out.
    logic [7:0] mem_m [4];
    logic [7:0] rd_m;

    sync_ram_sp dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .wdata      (wdata),
`ifdef SYNC_RAM_PARITY_EN
        .rdata      (rdata),
        .parity_err (parity_err)
`else
        .rdata      (rdata)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mem_m[i] = 8'h00;
        rd_m = 8'h00;
    endtask

    // Drive one access, clock it, and advance the model. Inputs change and
    // outputs are sampled 1ns after the rising edge.
    task automatic cycle(input logic w, input logic r, input logic [1:0] a, input logic [7:0] d);
        wr_en = w;
        rd_en = r;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        if (r) rd_m = mem_m[a];
        if (w) mem_m[a] = d;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        addr  = 2'd0;
        wdata = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_rdata got=%h exp=00", rdata);
        end
        // Writes attempted during reset must be ignored.
        wr_en = 1'b1;
        wdata = 8'hff;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            cycle(1'b0, 1'b1, 2'(a), 8'h00);
            checks++;
            if (rdata !== 8'h00) begin
                failures++;
                $display("FAIL reset_read_a%0d got=%h exp=00", a, rdata);
            end
        end
    endtask

    task automatic test_write_read();
        logic [7:0] vals [4];
        vals[0] = 8'h6b; vals[1] = 8'h7e; vals[2] = 8'h85; vals[3] = 8'hfb;
        for (int a = 0; a < 4; a++) cycle(1'b1, 1'b0, 2'(a), vals[a]);
        for (int a = 0; a < 4; a++) begin
            cycle(1'b0, 1'b1, 2'(a), 8'h00);
            checks++;
            if (rdata !== vals[a]) begin
                failures++;
                $display("FAIL wr_rd_a%0d got=%h exp=%h", a, rdata, vals[a]);
            end
        end
    endtask

    task automatic test_overwrite();
        logic [7:0] exp [4];
        exp[0] = 8'h52; exp[1] = 8'h7e; exp[2] = 8'h85; exp[3] = 8'hfb;
        cycle(1'b1, 1'b0, 2'd0, 8'h99);
        cycle(1'b1, 1'b0, 2'd0, 8'h52);
        for (int a = 0; a < 4; a++) begin
            cycle(1'b0, 1'b1, 2'(a), 8'h00);
            checks++;
            if (rdata !== exp[a]) begin
                failures++;
                $display("FAIL overwrite_a%0d got=%h exp=%h", a, rdata, exp[a]);
            end
        end
    endtask

    task automatic test_read_before_write();
        cycle(1'b1, 1'b0, 2'd1, 8'h11);
        cycle(1'b1, 1'b1, 2'd1, 8'h22);
        checks++;
        if (rdata !== 8'h11) begin
            failures++;
            $display("FAIL rbw_old got=%h exp=11", rdata);
        end
        cycle(1'b0, 1'b1, 2'd1, 8'h00);
        checks++;
        if (rdata !== 8'h22) begin
            failures++;
            $display("FAIL rbw_new got=%h exp=22", rdata);
        end
    endtask

    task automatic test_hold();
        cycle(1'b0, 1'b1, 2'd2, 8'h00);
        checks++;
        if (rdata !== 8'h85) begin
            failures++;
            $display("FAIL hold_read got=%h exp=85", rdata);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 2'(i), 8'h00);
            checks++;
            if (rdata !== 8'h85) begin
                failures++;
                $display("FAIL hold_cyc%0d got=%h exp=85", i, rdata);
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 1'b0, 2'd3, 8'hc3);
        cycle(1'b0, 1'b1, 2'd3, 8'h00);
        checks++;
        if (rdata !== 8'hc3) begin
            failures++;
            $display("FAIL areset_pre got=%h exp=c3", rdata);
        end
        // Assert reset between edges, with a write pending, and look before
        // the next edge arrives.
        #2;
        wr_en = 1'b1;
        addr  = 2'd0;
        wdata = 8'hee;
        reset = 1'b1;
        #1;
        checks++;
        if (rdata !== 8'h00) begin
            failures++;
            $display("FAIL areset_immediate got=%h exp=00", rdata);
        end
        model_reset();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            cycle(1'b0, 1'b1, 2'(a), 8'h00);
            checks++;
            if (rdata !== 8'h00) begin
                failures++;
                $display("FAIL areset_read_a%0d got=%h exp=00", a, rdata);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 8'($urandom));
            checks++;
            if (rdata !== rd_m) begin
                failures++;
                $display("FAIL random_cyc%0d got=%h exp=%h", i, rdata, rd_m);
            end
`ifdef SYNC_RAM_PARITY_EN
            checks++;
            if (parity_err !== 1'b0) begin
                failures++;
                $display("FAIL random_parity_cyc%0d got=%b exp=0", i, parity_err);
            end
`endif
        end
    endtask

`ifdef SYNC_RAM_PARITY_EN
    task automatic test_parity();
        cycle(1'b1, 1'b0, 2'd2, 8'h85);
        cycle(1'b1, 1'b0, 2'd1, 8'h3c);
        dut.mem_q[2] = dut.mem_q[2] ^ 8'h01;
        cycle(1'b0, 1'b1, 2'd2, 8'h00);
        checks++;
        if (parity_err !== 1'b1) begin
            failures++;
            $display("FAIL parity_corrupt got=%b exp=1", parity_err);
        end
        cycle(1'b0, 1'b1, 2'd1, 8'h00);
        checks++;
        if (parity_err !== 1'b0) begin
            failures++;
            $display("FAIL parity_clean got=%b exp=0", parity_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_overwrite();
        test_read_before_write();
        test_hold();
        test_async_reset();
        test_random();
`ifdef SYNC_RAM_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_ram_sp.md
Name: sync_ram_sp

Overview:
- Small single-port synchronous read/write RAM used as the DUT behind the mem_intf interface.
- Independent write-enable and read-enable; registered read data.
- Default geometry is 4 words x 8 bits; both dimensions are parameterised.
- Written through a driver and checked by a scoreboard that compares read data against previously written data.

Parameters:
- ADDR_WIDTH, default 2: address bits; depth = 2**ADDR_WIDTH (4 words).
- DATA_WIDTH, default 8: word width in bits.
- RESET_VALUE, default 0: value loaded into every word and into rdata on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- addr  input  ADDR_WIDTH  word address for both read and write.
- wr_en  input  1  write enable; sampled on rising clk.
- rd_en  input  1  read enable; sampled on rising clk.
- wdata  input  DATA_WIDTH  write data.
- rdata  output  DATA_WIDTH  registered read data.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high; reset assertion acts immediately, without waiting for a clk edge.
- While reset is high:
  - every storage word = RESET_VALUE;
  - rdata = RESET_VALUE;
  - wr_en and rd_en are ignored.
- Reset deasserts synchronously to operation: the first rising edge with reset low may perform an access.
- Write: on rising clk with wr_en=1, mem[addr] <= wdata. The new value is visible to a read starting on the next edge.
- Read:
  - on rising clk with rd_en=1, rdata <= mem[addr]; latency is 1 cycle (data valid after the sampling edge);
  - with rd_en=0, rdata holds its last value.
- Simultaneous wr_en=1 and rd_en=1 at the same addr: read-before-write. rdata gets the old contents; the array gets wdata.
- Simultaneous enables at different addresses are not possible: the block has a single address port.
- Address covers the full 2**ADDR_WIDTH range. There is no out-of-range case and no wrap logic.
- Writing the same address repeatedly: last write wins.
- wr_en=0 and rd_en=0: no state change.
- Reset mid-operation:
  - any in-flight access is discarded;
  - contents revert to RESET_VALUE;
  - no partial write is permitted.
- X on addr while an enable is high is a stimulus error. The design does not need to handle it.

Optional Feature:
- Macro: SYNC_RAM_PARITY_EN.
- When defined:
  - each word stores one extra even-parity bit, computed from wdata on write;
  - reset initialises stored parity consistently with RESET_VALUE;
  - an extra output port parity_err (1 bit, registered) is added;
  - on a read, parity_err <= 1 if the stored parity does not match the XOR of the stored data, else 0;
  - parity_err updates only on read edges and resets to 0.
- When not defined:
  - no parity storage and no parity_err port;
  - port list is exactly as above.

Test Plan:
- Assert reset, release, read addr 0..3 -> rdata = 0x00 each, one cycle after rd_en.
- Write addr0=0x6b, addr1=0x7e, addr2=0x85, addr3=0xfb, then read each -> 0x6b, 0x7e, 0x85, 0xfb respectively.
- Overwrite addr0 with 0x52, then read addr0 -> 0x52 (last write wins); other addresses unchanged.
- Write addr1=0x11, then same-cycle wr_en=1/rd_en=1 at addr1 with wdata=0x22 -> rdata=0x11 that cycle, a following read -> 0x22.
- Read addr2 (0x85), then hold rd_en=0 for 3 cycles while changing addr -> rdata stays 0x85.
- Assert reset asynchronously mid-clock after writes -> rdata drops to 0x00 immediately; subsequent reads of all addresses -> 0x00.
- With SYNC_RAM_PARITY_EN: force-corrupt one stored data bit -> read of that word gives parity_err=1; clean words give 0.
